// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants, FSM state and code-pair types for the convolutional encoder and Viterbi decoder
package viterbi_pkg;
  localparam int K = 3;
  localparam int TAIL_LEN = K - 1;
  localparam logic [K-1:0] G0_DEF = 3'b111;
  localparam logic [K-1:0] G1_DEF = 3'b101;
  typedef enum logic [1:0] {S_DATA, S_TAIL1, S_TAIL2} enc_state_t;
  typedef logic [1:0] sym_pair_t;
endpackage

// File: rtl/conv_enc_parity.sv
// conv_enc_parity: combinational rate-1/2 parity pair for tap vector {d, sr}
module conv_enc_parity
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic                d,
  input  logic [TAIL_LEN-1:0] sr,
  output sym_pair_t           pair
);
  logic [K-1:0] v;
  assign v = {d, sr};
  assign pair = {^(G1 & v), ^(G0 & v)};
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: framed rate-1/2 K=3 encoder with zero tail; CONV_ENC_ERR_INJECT_EN adds err_flip pair corruption
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output sym_pair_t        tx_pair,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
`ifdef CONV_ENC_ERR_INJECT_EN
  input  logic [1:0]       err_flip,
`endif
  output logic             busy,
  output logic [CNT_W-1:0] sym_cnt
);
  enc_state_t state;
  logic [TAIL_LEN-1:0] sr;
  logic restart, room, in_fire, out_fire, gen, d;
  sym_pair_t par, flip;
`ifdef CONV_ENC_ERR_INJECT_EN
  assign flip = err_flip;
`else
  assign flip = '0;
`endif
  assign room = !out_valid || out_ready;
  assign in_ready = (state == S_DATA) && room;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign gen = (state == S_DATA) ? in_fire : room;
  assign d = (state == S_DATA) && in_bit;
  conv_enc_parity #(.G0(G0), .G1(G1)) u_parity (.d(d), .sr(sr), .pair(par));
  // pair generation, tail sequencing, busy tracking and per-frame pair count
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_DATA;
      sr        <= '0;
      tx_pair   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      sym_cnt   <= '0;
      restart   <= 1'b0;
    end else begin
      if (gen) begin
        tx_pair   <= par ^ flip;
        sr        <= {d, sr[1]};
        out_valid <= 1'b1;
        out_last  <= state == S_TAIL2;
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      state <= !gen ? state :
               state == S_TAIL1 ? S_TAIL2 :
               state == S_TAIL2 ? S_DATA :
               in_last ? S_TAIL1 : S_DATA;
      busy <= in_fire || (busy && !(out_fire && out_last));
      if (out_fire) begin
        sym_cnt <= restart ? CNT_W'(1) : sym_cnt + CNT_W'(!(&sym_cnt));
        restart <= out_last;
      end
    end
  end
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: table vectors, corner sequences and randomized frames against a sum-mod-2 reference model
module tb_conv_encoder;
  logic clk = 1'b0, rst = 1'b1;
  logic in_bit = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last, busy;
  logic [1:0] tx_pair;
  logic [15:0] sym_cnt;
`ifdef CONV_ENC_ERR_INJECT_EN
  logic [1:0] err_flip = 2'b00;
  int flip_idx = -1;
  logic [1:0] flip_val = 2'b00;
`endif
  int n_cmp = 0, n_err = 0;
  bit rdy_rand = 1'b0;
  logic [2:0] got_q[$];
  logic [15:0] cnt_q[$];
  logic [2:0] exp_q[$];

  typedef struct {
    int n;
    logic [7:0] bits;
    logic [19:0] pairs;
  } vec_t;
  vec_t vecs[5];

  conv_encoder dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .tx_pair(tx_pair), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready),
`ifdef CONV_ENC_ERR_INJECT_EN
    .err_flip(err_flip),
`endif
    .busy(busy), .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      got_q.push_back({out_last, tx_pair});
      cnt_q.push_back(sym_cnt);
    end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add_model(input int n, input logic [31:0] bits);
    for (int i = 0; i < n + 2; i++) begin
      int d0, d1, d2;
      d0 = (i < n) ? int'(bits[i]) : 0;
      d1 = (i >= 1 && i - 1 < n) ? int'(bits[i-1]) : 0;
      d2 = (i >= 2 && i - 2 < n) ? int'(bits[i-2]) : 0;
      exp_q.push_back({i == n + 1, 1'((d0 + d2) % 2), 1'((d0 + d1 + d2) % 2)});
    end
  endtask

  task automatic run_frame(input int n, input logic [31:0] bits, input bit gaps);
    bit fired;
    int budget;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      in_valid = 1'b1;
      in_bit = bits[i];
      in_last = (i == n - 1);
`ifdef CONV_ENC_ERR_INJECT_EN
      err_flip = (i == flip_idx) ? flip_val : 2'b00;
`endif
      fired = 1'b0;
      budget = 0;
      while (!fired) begin
        @(negedge clk);
        fired = in_ready;
        tick();
        if (++budget > 300 && !fired) begin
          n_cmp++;
          n_err++;
          $display("FAIL in_fire_timeout: bit %0d never accepted", i);
          fired = 1'b1;
        end
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      in_bit = 1'b0;
    end
`ifdef CONV_ENC_ERR_INJECT_EN
    err_flip = 2'b00;
`endif
  endtask

  task automatic wait_pairs(input int k);
    int b = 0;
    while (got_q.size() < k && b < 400) begin
      tick();
      b++;
    end
    repeat (3) tick();
    check("pair_count", got_q.size(), k);
  endtask

  task automatic clear_q;
    got_q.delete();
    cnt_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_model(input string name);
    wait_pairs(exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_pair%0d", name, i), got_q[i], exp_q[i]);
    clear_q();
  endtask

  initial begin
    int low;
    vecs[0] = '{4, 8'b0000_1101, 20'({2'b11, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11})};
    vecs[1] = '{1, 8'b0000_0001, 20'({2'b11, 2'b01, 2'b11})};
    vecs[2] = '{2, 8'b0000_0011, 20'({2'b11, 2'b10, 2'b10, 2'b11})};
    vecs[3] = '{1, 8'b0000_0000, 20'({2'b00, 2'b00, 2'b00})};
    vecs[4] = '{3, 8'b0000_0010, 20'({2'b00, 2'b11, 2'b01, 2'b11, 2'b00})};

    repeat (2) tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_tx_pair", tx_pair, 0);
    check("rst_busy", busy, 0);
    check("rst_sym_cnt", sym_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].n, 32'(vecs[v].bits), 1'b0);
      wait_pairs(vecs[v].n + 2);
      for (int i = 0; i < vecs[v].n + 2 && i < got_q.size(); i++) begin
        check($sformatf("vec%0d_pair%0d", v, i), got_q[i][1:0], vecs[v].pairs[2*i +: 2]);
        check($sformatf("vec%0d_last%0d", v, i), got_q[i][2], i == vecs[v].n + 1);
      end
      @(negedge clk);
      check($sformatf("vec%0d_sym_cnt", v), sym_cnt, vecs[v].n + 2);
      check($sformatf("vec%0d_busy", v), busy, 0);
      tick();
      clear_q();
    end

    add_model(1, 32'd1);
    run_frame(1, 32'd1, 1'b0);
    low = 0;
    repeat (5) begin
      @(negedge clk);
      low += int'(!in_ready);
    end
    check("tail_in_ready_low_cycles", low, 2);
    compare_model("single");

    add_model(4, 32'b1101);
    fork
      run_frame(4, 32'b1101, 1'b0);
      begin
        int b = 0;
        while (got_q.size() < 2 && b < 100) begin
          tick();
          b++;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check($sformatf("stall%0d_tx_pair", c), tx_pair, exp_q[2][1:0]);
          check($sformatf("stall%0d_out_valid", c), out_valid, 1);
          check($sformatf("stall%0d_in_ready", c), in_ready, 0);
          check($sformatf("stall%0d_out_last", c), out_last, 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    compare_model("stall");

    run_frame(4, 32'b1101, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sym_cnt", sym_cnt, 0);
    check("abort_in_ready", in_ready, 1);
    tick();
    clear_q();
    add_model(4, 32'b1101);
    run_frame(4, 32'b1101, 1'b0);
    compare_model("after_abort");
    @(negedge clk);
    check("after_abort_sym_cnt", sym_cnt, 6);
    tick();

    add_model(1, 32'd1);
    add_model(1, 32'd1);
    run_frame(1, 32'd1, 1'b0);
    run_frame(1, 32'd1, 1'b0);
    wait_pairs(6);
    if (cnt_q.size() >= 5) begin
      check("b2b_cnt_before_b", cnt_q[3], 3);
      check("b2b_cnt_after_b_first", cnt_q[4], 1);
    end
    compare_model("b2b");

`ifdef CONV_ENC_ERR_INJECT_EN
    flip_idx = 1;
    flip_val = 2'b01;
    add_model(4, 32'b1101);
    exp_q[1] = exp_q[1] ^ 3'b001;
    run_frame(4, 32'b1101, 1'b0);
    flip_idx = -1;
    compare_model("err_inject");
`endif

    rdy_rand = 1'b1;
    for (int f = 0; f < 20; f++) begin
      int n;
      logic [31:0] bits;
      n = $urandom_range(1, 12);
      bits = $urandom;
      add_model(n, bits);
      run_frame(n, bits, 1'b1);
      compare_model($sformatf("rnd%0d", f));
      @(negedge clk);
      check($sformatf("rnd%0d_sym_cnt", f), sym_cnt, n + 2);
      check($sformatf("rnd%0d_busy", f), busy, 0);
      tick();
    end
    rdy_rand = 1'b0;
    out_ready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
